// File: rtl/pcm_pkg.sv
// pcm_pkg: shared PCM widths, sample types and ramp state encoding
package pcm_pkg;
    localparam int PCM_W = 16;
    localparam int VOL_UNITY = 16;
    typedef logic signed [PCM_W-1:0] pcm_t;
    typedef logic signed [PCM_W:0] pcm_delta_t;
    typedef enum logic {IDLE, RAMP} state_t;
endpackage

// File: rtl/pcm_ramp.sv
// pcm_ramp: linear ramp from the current output to a new target over 2^STEP_LOG2 clocks
module pcm_ramp
    import pcm_pkg::*;
#(
    parameter int STEP_LOG2 = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  pcm_t target,
    output pcm_t pcm_out,
    output logic busy,
    output logic overrun
);
    localparam int AW = PCM_W + 1 + STEP_LOG2;
    logic signed [AW-1:0] acc, acc_nx;
    pcm_delta_t delta;
    pcm_t start, pcm_nx;
    logic [STEP_LOG2-1:0] cnt;
    logic last;
    state_t state;
    always_comb begin
        acc_nx = acc + AW'(delta);
        pcm_nx = start + pcm_t'(acc_nx >>> STEP_LOG2);
        last = &cnt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            delta <= '0;
            start <= '0;
            cnt <= '0;
            state <= IDLE;
            pcm_out <= '0;
            busy <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                start <= pcm_out;
                delta <= pcm_delta_t'(target) - pcm_delta_t'(pcm_out);
                acc <= '0;
                cnt <= '0;
                state <= RAMP;
                busy <= 1'b1;
                overrun <= state == RAMP && !last;
            end else if (state == RAMP) begin
                acc <= acc_nx;
                pcm_out <= pcm_nx;
                cnt <= cnt + 1'b1;
                if (last) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: rtl/pcm_interp.sv
// pcm_interp: stereo mixdown, volume gain and clock-rate linear interpolation of PCM samples
module pcm_interp
    import pcm_pkg::*;
#(
    parameter int STEP_LOG2 = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  pcm_t       snd_left,
    input  pcm_t       snd_right,
    input  logic       sample,
    input  logic [4:0] vol,
    input  logic       mute,
    output pcm_t       pcm_out,
    output logic       busy,
    output logic       overrun
);
    pcm_t mix_q, tgt_q, mix_d, tgt_d;
    logic [4:0] v;
    logic v1, v2;
    always_comb begin
        mix_d = pcm_t'((pcm_delta_t'(snd_left) + pcm_delta_t'(snd_right)) >>> 1);
        v = vol > 5'(VOL_UNITY) ? 5'(VOL_UNITY) : vol;
        tgt_d = mute ? '0 : pcm_t'((22'(mix_q) * 22'($signed({1'b0, v}))) >>> 4);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_q <= '0;
            tgt_q <= '0;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            v1 <= sample;
            v2 <= v1;
            if (sample) mix_q <= mix_d;
            if (v1) tgt_q <= tgt_d;
        end
    end
    pcm_ramp #(.STEP_LOG2(STEP_LOG2)) u_ramp (
        .clk(clk),
        .rst_n(rst_n),
        .load(v2),
        .target(tgt_q),
        .pcm_out(pcm_out),
        .busy(busy),
        .overrun(overrun)
    );
endmodule

// File: tb/tb_pcm_interp.sv
// tb_pcm_interp: directed stimulus with a queue scoreboard checked whenever a ramp completes
module tb_pcm_interp;
    import pcm_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, sample = 1'b0, mute = 1'b0;
    pcm_t snd_left = '0, snd_right = '0, pcm_out;
    logic [4:0] vol = 5'd16;
    logic busy, overrun;
    int errors = 0, checks = 0;
    pcm_t exp_q[$];

    always #5 clk = ~clk;

    pcm_interp #(.STEP_LOG2(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .snd_left(snd_left),
        .snd_right(snd_right),
        .sample(sample),
        .vol(vol),
        .mute(mute),
        .pcm_out(pcm_out),
        .busy(busy),
        .overrun(overrun)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic strobe(input int l, input int r);
        snd_left = pcm_t'(l);
        snd_right = pcm_t'(r);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
    endtask

    task automatic settle(input string name, input int l, input int r, input int exp, input int dir);
        int bad, prev;
        exp_q.push_back(pcm_t'(exp));
        strobe(l, r);
        bad = 0;
        prev = pcm_out;
        repeat (260) begin
            @(negedge clk);
            if ((dir > 0 && pcm_out < prev) || (dir < 0 && pcm_out > prev)) bad++;
            prev = pcm_out;
        end
        check({name, "_mono"}, bad, 0);
        check({name, "_final"}, pcm_out, exp);
        check({name, "_busy"}, busy, 0);
    endtask

    initial begin : monitor
        logic bp;
        bp = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bp && !busy) begin
                check("sb_nonempty", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("sb_done", pcm_out, exp_q.pop_front());
            end
            bp = busy;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int bad, prev, pb, ovc;
        repeat (5) @(negedge clk);
        check("rst_pcm", pcm_out, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (pcm_out !== 0 || busy !== 0 || overrun !== 0) bad++;
        end
        check("idle_bad_cycles", bad, 0);

        vol = 5'd16;
        exp_q.push_back(pcm_t'(1000));
        strobe(1000, 1000);
        bad = 0;
        prev = pcm_out;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (pcm_out < prev) bad++;
            prev = pcm_out;
            if (k == 1) check("basic_busy_e1", busy, 0);
            if (k == 2) check("basic_busy_e2", busy, 1);
            if (k == 2) check("basic_pcm_e2", pcm_out, 0);
            if (k == 3) check("basic_pcm_e3", pcm_out, 3);
            if (k == 130) check("basic_half", pcm_out, 500);
            if (k == 257) check("basic_busy_e257", busy, 1);
            if (k == 258) check("basic_pcm_e258", pcm_out, 1000);
            if (k == 258) check("basic_busy_e258", busy, 0);
        end
        check("basic_mono", bad, 0);

        settle("fs_hi", 32767, 32767, 32767, 1);
        settle("fs_lo", -32768, -32768, -32768, -1);
        vol = 5'd8;
        settle("vol8", 4000, 4000, 2000, 1);
        vol = 5'd31;
        settle("vol31", 4000, 4000, 4000, 1);
        mute = 1'b1;
        settle("mute", 4000, 4000, 0, -1);
        mute = 1'b0;
        vol = 5'd16;
        settle("floor", 1, -2, -1, -1);
        mute = 1'b1;
        settle("zero", 5, 5, 0, 1);
        mute = 1'b0;

        strobe(10000, 10000);
        repeat (99) @(negedge clk);
        exp_q.push_back(pcm_t'(-5000));
        strobe(-5000, -5000);
        @(negedge clk);
        pb = pcm_out;
        check("intr_step99", pb, 3867);
        check("intr_ovr_before", overrun, 0);
        @(negedge clk);
        check("intr_ovr", overrun, 1);
        check("intr_continuity", pcm_out, pb);
        check("intr_busy", busy, 1);
        ovc = int'(overrun);
        for (int k = 103; k <= 358; k++) begin
            @(negedge clk);
            if (overrun) ovc++;
            if (k == 103) check("intr_ovr_after", overrun, 0);
            if (k == 103) check("intr_first_step", pcm_out, 3832);
            if (k == 357) check("intr_busy_e357", busy, 1);
        end
        check("intr_final", pcm_out, -5000);
        check("intr_done", busy, 0);
        check("intr_ovr_pulses", ovc, 1);

        strobe(2000, 2000);
        repeat (51) @(negedge clk);
        check("arst_busy_before", busy, 1);
        snd_left = pcm_t'(3000);
        snd_right = pcm_t'(3000);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_pcm", pcm_out, 0);
        check("arst_busy", busy, 0);
        check("arst_ovr", overrun, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (pcm_out !== 0 || busy !== 0) bad++;
        end
        check("arst_stale_bad", bad, 0);
        check("sb_leftover", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
